// File: rtl/seq_approx_div_pkg.sv
// Shared widths, state encoding and operand payload for the sequential approximate divider.
package seq_approx_div_pkg;

    localparam int unsigned DVD_W = 8;
    localparam int unsigned DVS_W = 4;
    localparam int unsigned R_W   = 5;
    localparam int unsigned CNT_W = 3;

    localparam logic [DVD_W-1:0] DIV0_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DVD_W-1:0] dividend;
        logic [DVS_W-1:0] divisor;
    } operands_t;

endpackage

// File: rtl/seq_approx_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step
    import seq_approx_div_pkg::*;
(
    input  logic [R_W-1:0]   r,
    input  logic             dvd_bit,
    input  logic [DVS_W-1:0] divisor,
    output logic [R_W-1:0]   r_next_c,
    output logic             q_bit_c
);

    logic [R_W:0] t;
    logic [R_W:0] dvs_ext;

    // r stays below the divisor, so the upper bits of t are zero and the result fits in R_W bits
    always_comb begin
        t        = {r, dvd_bit};
        dvs_ext  = (R_W+1)'(divisor);
        q_bit_c  = (t >= dvs_ext);
        r_next_c = q_bit_c ? R_W'(t - dvs_ext) : R_W'(t);
    end

endmodule

// File: rtl/seq_approx_divider.sv
// Sequential restoring divider 8b/4b; APPROX_LSBS skips the final steps and zeroes those quotient bits.
module seq_approx_divider
    import seq_approx_div_pkg::*;
#(
    parameter int unsigned APPROX_LSBS = 0
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      ITER      = DVD_W - APPROX_LSBS;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

    state_t           state;
    state_t           state_next;
    operands_t        op;
    logic [R_W-1:0]   r;
    logic [DVD_W-2:0] q_acc;
    logic [CNT_W-1:0] cnt;
    logic [R_W-1:0]   r_next_c;
    logic             q_bit_c;
    logic             accept_c;
    logic             last_c;
    logic [DVD_W-1:0] q_final_c;

    assign accept_c  = (state == IDLE) && in_valid && in_ready;
    assign last_c    = (cnt == LAST_STEP);
    assign q_final_c = DVD_W'({q_acc, q_bit_c} << APPROX_LSBS);

    div_step u_step (
        .r        (r),
        .dvd_bit  (op.dividend[DVD_W-1]),
        .divisor  (op.divisor),
        .r_next_c (r_next_c),
        .q_bit_c  (q_bit_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a zero divisor bypasses the iterations entirely
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = (divisor == '0) ? DONE : CALC;
            CALC:    if (last_c) state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op          <= '0;
            r           <= '0;
            q_acc       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept_c) begin
            op.dividend <= dividend;
            op.divisor  <= divisor;
            r           <= '0;
            q_acc       <= '0;
            cnt         <= '0;
            if (divisor == '0) begin
                quotient    <= DIV0_QUOT;
                remainder   <= dividend[DVS_W-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            op.dividend <= {op.dividend[DVD_W-2:0], 1'b0};
            r           <= r_next_c;
            q_acc       <= {q_acc[DVD_W-3:0], q_bit_c};
            cnt         <= cnt + CNT_W'(1);
            if (last_c) begin
                quotient    <= q_final_c;
                remainder   <= (APPROX_LSBS == 0) ? r_next_c[DVS_W-1:0] : '0;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_approx_divider.sv
// Bench for seq_approx_divider: three instances (APPROX_LSBS = 0, 2, 3) against an arithmetic reference.
module tb_seq_approx_divider;

    logic       clk;
    logic       rst_n;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       vld  [3];
    logic       ordy [3];
    logic       rdy  [3];
    logic       ov   [3];
    logic [7:0] quo  [3];
    logic [3:0] rem  [3];
    logic       dbz  [3];

    int n_vec;
    int n_bad;

    seq_approx_divider #(.APPROX_LSBS(0)) u_a0 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[0]), .out_ready(ordy[0]),
        .quotient(quo[0]), .remainder(rem[0]), .div_by_zero(dbz[0])
    );

    seq_approx_divider #(.APPROX_LSBS(2)) u_a2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[1]), .out_ready(ordy[1]),
        .quotient(quo[1]), .remainder(rem[1]), .div_by_zero(dbz[1])
    );

    seq_approx_divider #(.APPROX_LSBS(3)) u_a3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[2]), .out_ready(ordy[2]),
        .quotient(quo[2]), .remainder(rem[2]), .div_by_zero(dbz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int approx_of(input int u);
        case (u)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    // Reference: truncated quotient with low k bits cleared; all-ones on divide by zero
    function automatic int model_q(input int a, input int b, input int k);
        if (b == 0) return 255;
        return ((a / b) >> k) << k;
    endfunction

    function automatic int model_r(input int a, input int b, input int k);
        if (b == 0) return a % 16;
        if (k != 0) return 0;
        return a % b;
    endfunction

    // One division on unit u; optional stall cycles of backpressure with ignored in_valid pulses
    task automatic run_op(input int u, input int a, input int b, input int stall);
        int k;
        int lat;
        int guard;
        int eq;
        int er;
        k  = approx_of(u);
        eq = model_q(a, b, k);
        er = model_r(a, b, k);
        guard = 0;
        while (rdy[u] !== 1'b1 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", int'(rdy[u]), 1);
        dividend = 8'(a);
        divisor  = 4'(b);
        vld[u]   = 1'b1;
        @(posedge clk); #1;
        vld[u]   = 1'b0;
        ordy[u]  = (stall == 0);
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        lat = 0;
        while (ov[u] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, (b == 0) ? 0 : 8 - k);
        check("quotient", int'(quo[u]), eq);
        check("remainder", int'(rem[u]), er);
        check("div_by_zero", int'(dbz[u]), (b == 0) ? 1 : 0);
        check("in_ready_busy", int'(rdy[u]), 0);
        for (int s = 0; s < stall; s++) begin
            vld[u]   = ~vld[u];
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
            @(posedge clk); #1;
            check("stall_valid", int'(ov[u]), 1);
            check("stall_quotient", int'(quo[u]), eq);
            check("stall_remainder", int'(rem[u]), er);
            check("stall_in_ready", int'(rdy[u]), 0);
        end
        vld[u]  = 1'b0;
        ordy[u] = 1'b1;
        @(posedge clk); #1;
        ordy[u] = 1'b0;
        check("valid_after_handshake", int'(ov[u]), 0);
        check("ready_after_handshake", int'(rdy[u]), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        dividend = '0;
        divisor  = '0;
        for (int i = 0; i < 3; i++) begin
            vld[i]  = 1'b0;
            ordy[i] = 1'b0;
        end

        // Reset values on every instance
        #2;
        for (int i = 0; i < 3; i++) begin
            check("rst_in_ready", int'(rdy[i]), 0);
            check("rst_out_valid", int'(ov[i]), 0);
            check("rst_quotient", int'(quo[i]), 0);
            check("rst_remainder", int'(rem[i]), 0);
            check("rst_div_by_zero", int'(dbz[i]), 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_held_low", int'(rdy[0]), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) check("in_ready_rise", int'(rdy[i]), 1);

        // Directed cases
        run_op(0, 200, 7, 0);
        run_op(0, 8'hA5, 0, 0);
        run_op(2, 255, 3, 0);
        run_op(0, 100, 9, 10);
        run_op(0, 77, 5, 0);
        run_op(0, 200, 7, 0);

        // Reset in the middle of 255/1
        dividend = 8'd255;
        divisor  = 4'd1;
        vld[0]   = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(ov[0]), 0);
        check("midrst_quotient", int'(quo[0]), 0);
        check("midrst_in_ready", int'(rdy[0]), 0);
        @(posedge clk); #1;
        check("midrst_hold_valid", int'(ov[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_low", int'(rdy[0]), 0);
        @(posedge clk); #1;
        check("midrst_ready_rise", int'(rdy[0]), 1);
        run_op(0, 9, 2, 0);

        // Boundary operands on both sweep units
        for (int u = 0; u < 2; u++) begin
            run_op(u, 0, 0, 0);
            run_op(u, 0, 1, 0);
            run_op(u, 0, 15, 0);
            run_op(u, 255, 1, 0);
            run_op(u, 255, 15, 0);
            run_op(u, 255, 0, 0);
            run_op(u, 15, 15, 1);
        end

        // Randomized sweep against the reference
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 2; u++) begin
                run_op(u, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 2)));
            end
        end
        for (int n = 0; n < 60; n++) begin
            run_op(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
